// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared CIC helpers: accumulator width, log2 functions, rounding modes
package cic_pkg;

  typedef enum logic [0:0] {
    RND_TRUNC     = 1'b0,
    RND_HALF_EVEN = 1'b1
  } rnd_mode_e;

  // Bit growth of an N-stage interpolator is (N-1)*log2(R), so this width never loses MSBs.
  function automatic int cic_iw(input int bw, input int n, input int log2_max_rate);
    return bw + (n - 1) * log2_max_rate;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int floor_log2(input logic [31:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/cic_norm_rs.sv
// rtl/cic_norm_rs.sv - arithmetic right shift with round-half-even and saturation to BW bits
module cic_norm_rs
  import cic_pkg::*;
#(
  parameter int        IW    = 37,
  parameter int        BW    = 16,
  parameter int        SW    = 5,
  parameter rnd_mode_e RMODE = RND_HALF_EVEN
) (
  input  logic [IW-1:0] din,
  input  logic [SW-1:0] shift,
  output logic [BW-1:0] dout,
  output logic          sat
);

  localparam logic signed [IW-1:0] MAX_OUT = {{(IW-BW+1){1'b0}}, {(BW-1){1'b1}}};
  localparam logic signed [IW-1:0] MIN_OUT = {{(IW-BW+1){1'b1}}, {(BW-1){1'b0}}};

  logic signed [IW-1:0] floor_q;
  logic signed [IW-1:0] rounded;
  logic        [IW-1:0] rem_mask;
  logic        [IW-1:0] rem;
  logic        [IW-1:0] half;
  logic                 round_up;

  // floor_q is floor(din/2^shift); rem is the non-negative discarded part, also for negative din.
  always_comb begin
    floor_q  = $signed(din) >>> shift;
    rem_mask = ~({IW{1'b1}} << shift);
    rem      = din & rem_mask;
    half     = (shift == '0) ? '0 : ({{(IW-1){1'b0}}, 1'b1} << (shift - SW'(1)));
    round_up = 1'b0;
    if (RMODE == RND_HALF_EVEN && shift != '0) begin
      round_up = (rem > half) || ((rem == half) && floor_q[0]);
    end
    rounded = floor_q + $signed({{(IW-1){1'b0}}, round_up});
    sat     = 1'b0;
    dout    = rounded[BW-1:0];
    if (rounded > MAX_OUT) begin
      dout = MAX_OUT[BW-1:0];
      sat  = 1'b1;
    end else if (rounded < MIN_OUT) begin
      dout = MIN_OUT[BW-1:0];
      sat  = 1'b1;
    end
  end

endmodule

// File: rtl/cic_interp_mc.sv
// rtl/cic_interp_mc.sv - multi-channel CIC interpolator with runtime rate and normalised output
module cic_interp_mc
  import cic_pkg::*;
#(
  parameter int BW            = 16,
  parameter int N             = 4,
  parameter int LOG2_MAX_RATE = 7,
  parameter int NCH           = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [LOG2_MAX_RATE:0] rate,
  input  logic                   strobe_in,
  input  logic                   strobe_out,
  input  logic [NCH*BW-1:0]      signal_in,
  output logic [NCH*BW-1:0]      signal_out,
  output logic                   out_valid,
  output logic [NCH-1:0]         sat_flag,
  output logic                   strobe_err,
  input  logic                   clear_flags
);

  localparam int IW = cic_iw(BW, N, LOG2_MAX_RATE);
  localparam int RW = LOG2_MAX_RATE + 1;
  localparam int SW = clog2((N - 1) * LOG2_MAX_RATE + 1);
  localparam logic [RW-1:0] MAX_RATE = RW'(1) << LOG2_MAX_RATE;

  logic [RW-1:0]     rate_q;
  logic              clr;
  logic              adv_in;
  logic              adv_out;
  int                log2_r;
  logic [SW-1:0]     shift_amt;
  logic [NCH*BW-1:0] norm_out;
  logic [NCH-1:0]    norm_sat;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rate_q <= '0;
    else        rate_q <= rate;
  end

  // A rate change is seen against the previous clock's sample, so the clear lands one clock later.
  assign clr     = ~enable | (rate != rate_q);
  assign adv_in  = strobe_in & strobe_out & ~clr;
  assign adv_out = strobe_out & ~clr;

  always_comb begin
    log2_r = 0;
    if (rate_q >= MAX_RATE)  log2_r = LOG2_MAX_RATE;
    else if (rate_q != '0)   log2_r = floor_log2(32'(rate_q));
    shift_amt = SW'((N - 1) * log2_r);
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic [IW-1:0] comb_q   [N];
    logic [IW-1:0] dly_q    [N];
    logic [IW-1:0] integ_q  [N];
    logic [IW-1:0] stage_in [N];
    logic [BW-1:0] x_in;

    assign x_in = signal_in[ch*BW +: BW];

    always_comb begin
      stage_in[0] = {{(IW-BW){x_in[BW-1]}}, x_in};
      for (int k = 1; k < N; k++) stage_in[k] = comb_q[k-1];
    end

    // Combs run at the input rate; the integrator chain zero-stuffs between input samples.
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < N; k++) begin
          comb_q[k]  <= '0;
          dly_q[k]   <= '0;
          integ_q[k] <= '0;
        end
      end else if (clr) begin
        for (int k = 0; k < N; k++) begin
          comb_q[k]  <= '0;
          dly_q[k]   <= '0;
          integ_q[k] <= '0;
        end
      end else begin
        if (adv_in) begin
          for (int k = 0; k < N; k++) begin
            comb_q[k] <= stage_in[k] - dly_q[k];
            dly_q[k]  <= stage_in[k];
          end
        end
        if (adv_out) begin
          integ_q[0] <= integ_q[0] + (adv_in ? comb_q[N-1] : '0);
          for (int k = 1; k < N; k++) integ_q[k] <= integ_q[k] + integ_q[k-1];
        end
      end
    end

    cic_norm_rs #(
      .IW    (IW),
      .BW    (BW),
      .SW    (SW),
      .RMODE (RND_HALF_EVEN)
    ) u_norm (
      .din   (integ_q[N-1]),
      .shift (shift_amt),
      .dout  (norm_out[ch*BW +: BW]),
      .sat   (norm_sat[ch])
    );
  end

  // Flag set takes priority over a coincident clear.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      signal_out <= '0;
      out_valid  <= 1'b0;
      sat_flag   <= '0;
      strobe_err <= 1'b0;
    end else begin
      out_valid <= strobe_out & enable;
      if (strobe_out & enable) signal_out <= norm_out;
      sat_flag   <= (sat_flag & ~{NCH{clear_flags}}) | ({NCH{strobe_out & enable}} & norm_sat);
      strobe_err <= (strobe_err & ~clear_flags) | (strobe_in & ~strobe_out & enable);
    end
  end

endmodule

// File: tb/tb_cic_interp_mc.sv
// tb/tb_cic_interp_mc.sv - directed self-checking bench for cic_interp_mc
module tb_cic_interp_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  rate = 8'd0;
  logic        strobe_in = 1'b0;
  logic        strobe_out = 1'b0;
  logic [31:0] signal_in = '0;
  logic [31:0] signal_out;
  logic        out_valid;
  logic [1:0]  sat_flag;
  logic        strobe_err;
  logic        clear_flags = 1'b0;

  cic_interp_mc dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .rate        (rate),
    .strobe_in   (strobe_in),
    .strobe_out  (strobe_out),
    .signal_in   (signal_in),
    .signal_out  (signal_out),
    .out_valid   (out_valid),
    .sat_flag    (sat_flag),
    .strobe_err  (strobe_err),
    .clear_flags (clear_flags)
  );

  always #5 clock = ~clock;

  typedef struct {
    int rate;
    int in0;
    int in1;
    int exp0;
    int exp1;
    int exp_sat;
  } vec_t;

  vec_t vecs [11];
  int   total = 0;
  int   bad = 0;
  int   phase = 0;
  int   xcount = 0;
  int   hold_on = 0;
  int   hold_exp0 = 0;
  int   hold_exp1 = 0;
  int   hold_bad = 0;
  int   h [40];
  int   hb [40];
  int   imp0 [200];
  int   imp1 [200];

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  function automatic int eff_rate(input int r);
    if (r == 0) return 1;
    if (r > 128) return 128;
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_dp(input int r);
    enable      = 1'b0;
    clear_flags = 1'b1;
    rate        = 8'(r);
    strobe_in   = 1'b0;
    strobe_out  = 1'b0;
    @(posedge clock);
    @(negedge clock);
    enable      = 1'b1;
    clear_flags = 1'b0;
    phase       = 0;
  endtask

  task automatic run_stream(input int r, input int count, input int d0, input int d1);
    for (int k = 0; k < count; k++) begin
      signal_in  = {16'(d1), 16'(d0)};
      strobe_in  = (phase % r) == 0;
      strobe_out = 1'b1;
      @(posedge clock);
      @(negedge clock);
      phase++;
      if (out_valid && $isunknown(signal_out)) xcount++;
      if (hold_on != 0 && out_valid &&
          (s16(signal_out[15:0]) != hold_exp0 || s16(signal_out[31:16]) != hold_exp1))
        hold_bad++;
    end
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int first;
    int mism;
    int tail;
    int sum;
    int sym;
    int len;
    int zero_seen;
    int early_valid;

    vecs[0]  = '{4,   1000,   -1000,  1000,   -1000,  0};
    vecs[1]  = '{1,   1234,   -5,     1234,   -5,     0};
    vecs[2]  = '{0,   7,      -7,     7,      -7,     0};
    vecs[3]  = '{2,   32767,  -32768, 32767,  -32768, 0};
    vecs[4]  = '{8,   -32768, 100,    -32768, 100,    0};
    vecs[5]  = '{5,   4096,   -4096,  8000,   -8000,  0};
    vecs[6]  = '{3,   4,      12,     14,     40,     0};
    vecs[7]  = '{3,   -4,     -12,    -14,    -40,    0};
    vecs[8]  = '{7,   100,    -3,     536,    -16,    0};
    vecs[9]  = '{6,   10000,  -10000, 32767,  -32768, 3};
    vecs[10] = '{200, 500,    -500,   500,    -500,   0};

    // 4th-order impulse response for R=8: four boxcars of length 8 convolved
    for (int i = 0; i < 40; i++) h[i] = 0;
    h[0] = 1;
    len = 1;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 40; i++) hb[i] = 0;
      for (int i = 0; i < len; i++)
        for (int j = 0; j < 8; j++) hb[i+j] += h[i];
      len += 7;
      for (int i = 0; i < 40; i++) h[i] = hb[i];
    end

    // reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_signal_out", int'(signal_out), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_sat_flag", int'(sat_flag), 0);
    check("rst_strobe_err", int'(strobe_err), 0);
    reset = 1'b1;
    @(negedge clock);

    // table-driven DC vectors
    for (int i = 0; i < 11; i++) begin
      r = eff_rate(vecs[i].rate);
      clear_dp(vecs[i].rate);
      run_stream(r, r * 10 + 8, vecs[i].in0, vecs[i].in1);
      check($sformatf("vec%0d_ch0", i), s16(signal_out[15:0]), vecs[i].exp0);
      check($sformatf("vec%0d_ch1", i), s16(signal_out[31:16]), vecs[i].exp1);
      check($sformatf("vec%0d_sat", i), int'(sat_flag), vecs[i].exp_sat);
    end

    // impulse at R=8
    clear_dp(8);
    for (int k = 0; k < 200; k++) begin
      signal_in  = (k == 0) ? {16'(-512), 16'(512)} : 32'd0;
      strobe_in  = (k % 8) == 0;
      strobe_out = 1'b1;
      @(posedge clock);
      @(negedge clock);
      imp0[k] = s16(signal_out[15:0]);
      imp1[k] = s16(signal_out[31:16]);
    end
    strobe_in  = 1'b0;
    strobe_out = 1'b0;
    first = -1;
    for (int k = 0; k < 200; k++) if (first < 0 && imp0[k] != 0) first = k;
    check("imp_found", int'(first >= 0 && first < 150), 1);
    if (first < 0 || first >= 150) first = 0;
    mism = 0;
    tail = 0;
    sum  = 0;
    sym  = 0;
    for (int j = 0; j < 29; j++) if (imp0[first+j] != h[j]) mism++;
    for (int k = first + 29; k < 200; k++) if (imp0[k] != 0) tail++;
    for (int k = 0; k < 200; k++) begin
      sum += imp0[k];
      if (imp1[k] != -imp0[k]) sym++;
    end
    check("imp_seq_mismatches", mism, 0);
    check("imp_tail_nonzero", tail, 0);
    check("imp_sum", sum, 4096);
    check("imp_ch1_mirror", sym, 0);

    // saturation at R=5 and the clear_flags interplay
    clear_dp(5);
    run_stream(5, 58, 32767, 0);
    check("sat_clamp_ch0", s16(signal_out[15:0]), 32767);
    check("sat_flag_set", int'(sat_flag), 1);
    clear_flags = 1'b1;
    run_stream(5, 1, 32767, 0);
    clear_flags = 1'b0;
    check("sat_set_wins_clear", int'(sat_flag), 1);
    run_stream(5, 58, 4096, 0);
    check("sat_drop_ch0", s16(signal_out[15:0]), 8000);
    check("sat_sticky", int'(sat_flag), 1);
    clear_flags = 1'b1;
    run_stream(5, 1, 4096, 0);
    clear_flags = 1'b0;
    check("sat_cleared", int'(sat_flag), 0);

    // strobe_in without strobe_out is dropped
    clear_dp(4);
    run_stream(4, 60, 1000, -1000);
    check("proto_err_idle", int'(strobe_err), 0);
    signal_in  = {16'(-20000), 16'(20000)};
    strobe_in  = 1'b1;
    strobe_out = 1'b0;
    @(posedge clock);
    @(negedge clock);
    strobe_in = 1'b0;
    check("proto_err_set", int'(strobe_err), 1);
    hold_on   = 1;
    hold_exp0 = 1000;
    hold_exp1 = -1000;
    hold_bad  = 0;
    run_stream(4, 60, 1000, -1000);
    hold_on = 0;
    check("proto_output_held", hold_bad, 0);
    check("proto_err_sticky", int'(strobe_err), 1);
    clear_flags = 1'b1;
    run_stream(4, 1, 1000, -1000);
    clear_flags = 1'b0;
    check("proto_err_cleared", int'(strobe_err), 0);

    // rate change 4 -> 16 mid-stream
    xcount    = 0;
    zero_seen = 0;
    rate      = 8'd16;
    phase     = 0;
    for (int k = 0; k < 3; k++) begin
      run_stream(16, 1, 1000, -1000);
      if (s16(signal_out[15:0]) == 0 && s16(signal_out[31:16]) == 0) zero_seen = 1;
    end
    check("rate_chg_cleared", zero_seen, 1);
    run_stream(16, 168, 1000, -1000);
    check("rate_chg_ch0", s16(signal_out[15:0]), 1000);
    check("rate_chg_ch1", s16(signal_out[31:16]), -1000);
    check("rate_chg_no_x", xcount, 0);

    // async reset between clock edges
    signal_in  = {16'(-20000), 16'(20000)};
    strobe_in  = 1'b1;
    strobe_out = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check("arst_pre_err", int'(strobe_err), 1);
    strobe_in  = 1'b0;
    strobe_out = 1'b1;
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("arst_signal_out", int'(signal_out), 0);
    check("arst_out_valid", int'(out_valid), 0);
    check("arst_sat_flag", int'(sat_flag), 0);
    check("arst_strobe_err", int'(strobe_err), 0);
    @(negedge clock);
    strobe_out = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    early_valid = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clock);
      @(negedge clock);
      if (out_valid) early_valid++;
    end
    check("arst_no_early_valid", early_valid, 0);
    strobe_out = 1'b1;
    @(posedge clock);
    @(negedge clock);
    strobe_out = 1'b0;
    check("arst_first_valid", int'(out_valid), 1);
    check("arst_first_value", int'(signal_out), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
